// File: rtl/apb_arb_pkg.sv
// Shared definitions for the APB round-robin arbiter.
//   arb_state_e : downstream transfer FSM state (IDLE, SETUP, ACCESS)
//   cnt_width() : width of the ACCESS-phase wait counter for a given timeout
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_e;

  // Bits needed to hold 0..timeout_cycles; never less than 1 so the counter
  // stays a legal vector when the timeout is disabled (timeout_cycles = 0).
  function automatic int cnt_width(input int timeout_cycles);
    int w;
    w = $clog2(timeout_cycles + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   i_req   : request vector, one bit per requester
//   i_ptr   : index with highest priority this round (owned by the parent)
//   o_gnt   : one-hot winner (0 when no request)
//   o_idx   : binary winner index (0 when no request)
//   o_valid : at least one request present
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_sel;

  // Scan N positions starting at the pointer, wrapping modulo N; the first
  // requesting position wins.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    w_sel   = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, i_ptr} + (IDX_W + 1)'(k);
      if (w_sum >= (IDX_W + 1)'(N)) w_sum = w_sum - (IDX_W + 1)'(N);
      w_sel = w_sum[IDX_W-1:0];
      if (!o_valid && i_req[w_sel]) begin
        o_valid      = 1'b1;
        o_gnt[w_sel] = 1'b1;
        o_idx        = w_sel;
      end
    end
  end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Shares one downstream APB master port between NUM_MASTERS upstream APB
// requesters with round-robin arbitration, whole-transfer grant hold and an
// ACCESS-phase timeout that completes with PSLVERR.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   s_psel_i .. s_pwdata_i : upstream requester APB inputs (packed per index)
//   s_prdata_o             : read data broadcast to all requesters
//   s_pready_o/s_pslverr_o : per-requester completion, only the winner's bit
//   m_*                    : downstream APB master port
//   grant_o                : one-hot owner of the current transfer
//   timeout_o              : one-cycle pulse on a timeout completion
//   dbg_state_o            : FSM state (arb_state_e encoding)
//
// Handshake: a requester asks by raising PSEL and holds PSEL and its controls
// stable until its PREADY bit is seen high; that PREADY cycle is the single
// completion cycle, and PRDATA/PSLVERR are valid only in it.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_MASTERS-1:0]               s_psel_i,
  input  logic [NUM_MASTERS-1:0]               s_penable_i,
  input  logic [NUM_MASTERS-1:0]               s_pwrite_i,
  input  logic [NUM_MASTERS*APB_ADDR_WIDTH-1:0] s_paddr_i,
  input  logic [NUM_MASTERS*APB_DATA_WIDTH-1:0] s_pwdata_i,
  output logic [APB_DATA_WIDTH-1:0]            s_prdata_o,
  output logic [NUM_MASTERS-1:0]               s_pready_o,
  output logic [NUM_MASTERS-1:0]               s_pslverr_o,
  output logic                                 m_psel_o,
  output logic                                 m_penable_o,
  output logic                                 m_pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]            m_paddr_o,
  output logic [APB_DATA_WIDTH-1:0]            m_pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0]            m_prdata_i,
  input  logic                                 m_pready_i,
  input  logic                                 m_pslverr_i,
  output logic [NUM_MASTERS-1:0]               grant_o,
  output logic                                 timeout_o,
  output logic [1:0]                           dbg_state_o
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT_CYCLES);

  arb_state_e                r_state;
  arb_state_e                w_state_nxt;
  logic [IDX_W-1:0]          r_ptr;
  logic [IDX_W-1:0]          r_win;
  logic [NUM_MASTERS-1:0]    r_gnt;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_pwrite;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [APB_DATA_WIDTH-1:0] r_pwdata;

  logic [NUM_MASTERS-1:0]    w_gnt_rr;
  logic [IDX_W-1:0]          w_idx_rr;
  logic                      w_req_valid;
  logic                      w_busy;
  logic                      w_access;
  logic                      w_timeout;
  logic                      w_done;
  logic                      w_unused_penable;

  // PENABLE from the requesters carries no information here: a request is
  // PSEL alone, and the downstream phases are generated locally.
  assign w_unused_penable = ^s_penable_i;

  rr_arbiter #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr (
    .i_req   (s_psel_i),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt_rr),
    .o_idx   (w_idx_rr),
    .o_valid (w_req_valid)
  );

  assign w_busy   = (r_state != IDLE);
  assign w_access = (r_state == ACCESS);

  // A peripheral answer in the cycle the counter hits the limit wins over
  // the timeout.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && w_access && !m_pready_i &&
                     (r_cnt == CNT_TO);
  assign w_done    = w_access && (m_pready_i || w_timeout);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_req_valid) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = ACCESS;
      ACCESS:  if (w_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_win    <= '0;
      r_gnt    <= '0;
      r_cnt    <= '0;
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Arbitration happens only in IDLE, so the completion cycle never
      // arbitrates and one IDLE cycle always separates transfers.
      if ((r_state == IDLE) && w_req_valid) begin
        r_win    <= w_idx_rr;
        r_gnt    <= w_gnt_rr;
        r_pwrite <= s_pwrite_i[w_idx_rr];
        r_paddr  <= s_paddr_i[w_idx_rr*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
        r_pwdata <= s_pwdata_i[w_idx_rr*APB_DATA_WIDTH +: APB_DATA_WIDTH];
        r_cnt    <= '0;
      end
      if (w_access) begin
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
        if (w_done) begin
          r_ptr <= (r_win == IDX_W'(NUM_MASTERS - 1)) ? '0 : r_win + IDX_W'(1);
        end
      end
    end
  end

  assign m_psel_o    = w_busy;
  assign m_penable_o = w_access;
  assign m_pwrite_o  = r_pwrite;
  assign m_paddr_o   = r_paddr;
  assign m_pwdata_o  = r_pwdata;

  assign grant_o     = w_busy ? r_gnt : '0;
  assign s_pready_o  = w_done ? r_gnt : '0;
  assign s_pslverr_o = (w_done && (w_timeout || m_pslverr_i)) ? r_gnt : '0;
  // Zero outside a genuine peripheral answer, including timeout completions.
  assign s_prdata_o  = (w_access && m_pready_i) ? m_prdata_i : '0;
  assign timeout_o   = w_timeout;
  assign dbg_state_o = r_state;

endmodule

// File: doc/apb_rr_arbiter.md
Name: apb_rr_arbiter

Overview:
- Shares one APB master port between NUM_MASTERS upstream APB requesters, for example the AXI-to-APB bridge and a debug/DMA APB master.
- Sits between those requesters and the peripheral APB address decoder.
- Each requester sees the block as an APB slave.
- Arbitration is round-robin. The grant is held for a whole transfer, and a per-transfer timeout returns PSLVERR if the peripheral never answers.

Parameters:
- NUM_MASTERS, 2, number of upstream requesters (2..8).
- APB_ADDR_WIDTH, 32, PADDR width.
- APB_DATA_WIDTH, 32, PWDATA/PRDATA width.
- TIMEOUT_CYCLES, 255, maximum ACCESS-phase wait cycles before forced error completion; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- s_psel_i  in  NUM_MASTERS  per-requester PSEL
- s_penable_i  in  NUM_MASTERS  per-requester PENABLE
- s_pwrite_i  in  NUM_MASTERS  per-requester PWRITE
- s_paddr_i  in  NUM_MASTERS*APB_ADDR_WIDTH  packed addresses, requester i at slice i
- s_pwdata_i  in  NUM_MASTERS*APB_DATA_WIDTH  packed write data
- s_prdata_o  out  APB_DATA_WIDTH  read data, broadcast to all requesters
- s_pready_o  out  NUM_MASTERS  per-requester PREADY
- s_pslverr_o  out  NUM_MASTERS  per-requester PSLVERR
- m_psel_o  out  1  downstream PSEL
- m_penable_o  out  1  downstream PENABLE
- m_pwrite_o  out  1  downstream PWRITE
- m_paddr_o  out  APB_ADDR_WIDTH  downstream PADDR
- m_pwdata_o  out  APB_DATA_WIDTH  downstream PWDATA
- m_prdata_i  in  APB_DATA_WIDTH  downstream PRDATA
- m_pready_i  in  1  downstream PREADY
- m_pslverr_i  in  1  downstream PSLVERR
- grant_o  out  NUM_MASTERS  one-hot owner of the current transfer; 0 in IDLE
- timeout_o  out  1  one-cycle pulse when a timeout completion occurs

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous, active-high, on rst_i.
- Reset values:
  - state = IDLE and rr pointer = 0.
  - All m_* outputs, s_pready_o, s_pslverr_o, grant_o and timeout_o are 0.
  - s_prdata_o and m_prdata_i passthrough are don't-care, but driven to 0 in reset.
- Request: requester i is requesting when s_psel_i[i]=1, whatever its PENABLE. The requester holds its PSEL and controls stable until it sees its PREADY.
- FSM IDLE:
  - If any request is present, pick the first requesting index at or after the rr pointer (wrapping modulo NUM_MASTERS).
  - Register the winner, latch its PWRITE/PADDR/PWDATA into output registers, then go to SETUP.
  - With no request, stay in IDLE.
- FSM SETUP: m_psel_o=1 and m_penable_o=0 for exactly 1 cycle, then go to ACCESS.
- FSM ACCESS:
  - m_psel_o=1 and m_penable_o=1; wait counter increments each cycle.
  - When m_pready_i=1, in the same cycle combinationally drive s_pready_o[win]=1, s_pslverr_o[win]=m_pslverr_i and s_prdata_o=m_prdata_i.
  - Next state is IDLE. The rr pointer becomes win+1, wrapping modulo NUM_MASTERS.
- Timeout: if TIMEOUT_CYCLES!=0 and the wait counter reaches TIMEOUT_CYCLES with m_pready_i=0:
  - Complete toward the requester with s_pready_o[win]=1, s_pslverr_o[win]=1, s_prdata_o=0, and pulse timeout_o.
  - Drop m_psel_o (abort) and go to IDLE; the pointer advances as above.
  - The counter is sized for TIMEOUT_CYCLES, saturating, and clears on entry to SETUP.
- Latency: an uncontended transfer asserts m_psel_o 1 cycle after the requester's PSEL. The requester's minimum transfer is 3 cycles (arbitration, SETUP, ACCESS).
- Idle gap: there is always exactly one IDLE cycle between consecutive downstream transfers. Arbitration is never done in the completion cycle.
- grant_o = one-hot(win) in SETUP and ACCESS, 0 in IDLE.
- s_pready_o / s_pslverr_o are 0 for every non-winning requester at all times.
- Requester drops PSEL mid-transfer (protocol violation): the downstream transfer still completes and the response is still pulsed on s_pready_o[win]. No other side effect.
- Reset mid-transfer: on the next edge state=IDLE, m_psel_o=0 and the pointer is 0; the outstanding transfer is lost.
- Simultaneous requests from all requesters: each one is served exactly once per NUM_MASTERS transfers.

Decomposition:
- Package apb_arb_pkg holds the state enum (IDLE, SETUP, ACCESS) and a localparam function for counter width (clog2 of TIMEOUT_CYCLES+1).
- Sub-module rr_arbiter handles request vector plus pointer and produces a one-hot grant and a binary index. It is purely combinational with the pointer owned by the parent.

Test Plan:
- Single write: requester 0 writes 0xDEADBEEF to 0x1A10_0004 with pready returned immediately → m_psel_o rises 1 cycle later, m_penable_o the cycle after, s_pready_o=2'b01 on cycle 3, m_pwdata_o=0xDEADBEEF.
- Contention: both requesters assert PSEL in the same cycle after reset → requester 0 is served first; requester 1 is served after 1 IDLE cycle. Repeating the pattern alternates 1,0,1,0.
- Wait states with read: the peripheral holds pready low for 4 ACCESS cycles and returns prdata=0x12345678 with pslverr=1 → the requester sees pready only in the 5th ACCESS cycle, with prdata=0x12345678 and pslverr=1.
- Timeout: with TIMEOUT_CYCLES=8 and pready never asserted → after 8 ACCESS cycles s_pready_o[win]=1, s_pslverr_o[win]=1, timeout_o is a single pulse, and m_psel_o=0 the next cycle.
- Reset mid-ACCESS: assert rst_i for 1 cycle during ACCESS → all outputs are 0 the next cycle and the next request is served from index 0.
- Fairness with 4 requesters (NUM_MASTERS=4): all hold PSEL continuously for 12 transfers → each is granted exactly 3 times, in order 0,1,2,3 repeated.
